alu_arbiter: RTL and testbench

Shares one instance of the team's combinational `alu` between two independent requesters, for example the main execute stage and the address/branch helper path, so that only one ALU is built. Each requester has its own valid/ready request channel and its own valid/ready response channel with a one-entry response buffer. Arbitration is round-robin, and results are registered one cycle after acceptance. Together the two requesters get at most one operation per cycle.

---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 94 +++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of the two requesters sharing one ALU
// req{0,1}_valid/ready, _a, _b, _funct3, _funct7, _tag : request channel per requester
// rsp{0,1}_valid/ready, _result, _tag                  : response channel per requester
// master = requester side, slave = arbiter side
interface alu_arbiter_if #(parameter int TAG_W = 4);
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_funct3, req1_funct3;
    logic [6:0]       req0_funct7, req1_funct7;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]      rsp0_result, rsp1_result;
    logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3, req0_funct7, req0_tag,
        output req1_valid, req1_a, req1_b, req1_funct3, req1_funct7, req1_tag,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_tag, rsp1_valid, rsp1_result, rsp1_tag,
        output rsp0_ready, rsp1_ready
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3, req0_funct7, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_funct3, req1_funct7, req1_tag,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_tag, rsp1_valid, rsp1_result, rsp1_tag,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
// alu         : RV32 integer ALU, funct3 selects op, funct7[5] selects SUB/SRA
// alu_arbiter : clk, rst_n (sync, active-low), bus (alu_arbiter_if.slave);
//               one accept per cycle, results registered into a one-entry buffer per requester
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] y
);
    logic               alt;
    logic               unused_funct7;
    logic [4:0]         shamt;
    logic signed [31:0] sra;
    assign alt = funct7[5];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign shamt = b[4:0];
    assign sra = $signed(a) >>> shamt;
    always_comb begin
        y = '0;
        case (funct3)
            3'b000:  y = alt ? a - b : a + b;
            3'b001:  y = a << shamt;
            3'b010:  y = {31'd0, $signed(a) < $signed(b)};
            3'b011:  y = {31'd0, a < b};
            3'b100:  y = a ^ b;
            3'b101:  y = alt ? sra : a >> shamt;
            3'b110:  y = a | b;
            default: y = a & b;
        endcase
    end
endmodule

module alu_arbiter #(parameter int TAG_W = 4) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    logic             prio_q, prio_d;
    logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [31:0]      rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
    logic [TAG_W-1:0] rsp0_tag_q, rsp0_tag_d, rsp1_tag_q, rsp1_tag_d;
    logic             elig0, elig1, gnt0, gnt1;
    logic [31:0]      alu_y;
    // a buffer being drained this cycle may be refilled on the same edge
    assign elig0 = rst_n && bus.req0_valid && (!rsp0_valid_q || bus.rsp0_ready);
    assign elig1 = rst_n && bus.req1_valid && (!rsp1_valid_q || bus.rsp1_ready);
    assign gnt0 = elig0 && (!elig1 || !prio_q);
    assign gnt1 = elig1 && (!elig0 || prio_q);
    alu u_alu (
        .a      (gnt1 ? bus.req1_a      : bus.req0_a),
        .b      (gnt1 ? bus.req1_b      : bus.req0_b),
        .funct3 (gnt1 ? bus.req1_funct3 : bus.req0_funct3),
        .funct7 (gnt1 ? bus.req1_funct7 : bus.req0_funct7),
        .y      (alu_y)
    );
    always_comb begin
        prio_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : prio_q;
        rsp0_valid_d = gnt0 || (rsp0_valid_q && !bus.rsp0_ready);
        rsp1_valid_d = gnt1 || (rsp1_valid_q && !bus.rsp1_ready);
        rsp0_result_d = gnt0 ? alu_y : rsp0_result_q;
        rsp1_result_d = gnt1 ? alu_y : rsp1_result_q;
        rsp0_tag_d = gnt0 ? bus.req0_tag : rsp0_tag_q;
        rsp1_tag_d = gnt1 ? bus.req1_tag : rsp1_tag_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_tag_q <= '0;
            rsp1_tag_q <= '0;
        end else begin
            prio_q <= prio_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_tag_q <= rsp0_tag_d;
            rsp1_tag_q <= rsp1_tag_d;
        end
    end
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.rsp0_tag = rsp0_tag_q;
    assign bus.rsp1_tag = rsp1_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    localparam int TAG_W = 4;
    localparam int EW = TAG_W + 32;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    int            total = 0;
    int            bad = 0;
    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    logic [EW-1:0] exp0 = '0;
    logic [EW-1:0] exp1 = '0;
    always #5 clk = ~clk;
    alu_arbiter_if #(.TAG_W(TAG_W)) bus ();
    alu_arbiter #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // pop/compare consumed responses first, then record newly accepted requests
    always @(negedge clk) begin : scoreboard
        logic [EW-1:0] e;
        if (bus.rsp0_valid && bus.rsp0_ready) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL rsp0_unexpected got=%h", {bus.rsp0_tag, bus.rsp0_result});
            end else begin
                e = q0.pop_front();
                if ({bus.rsp0_tag, bus.rsp0_result} !== e) begin
                    bad++;
                    $display("FAIL rsp0_data got=%h exp=%h", {bus.rsp0_tag, bus.rsp0_result}, e);
                end
            end
        end
        if (bus.rsp1_valid && bus.rsp1_ready) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL rsp1_unexpected got=%h", {bus.rsp1_tag, bus.rsp1_result});
            end else begin
                e = q1.pop_front();
                if ({bus.rsp1_tag, bus.rsp1_result} !== e) begin
                    bad++;
                    $display("FAIL rsp1_data got=%h exp=%h", {bus.rsp1_tag, bus.rsp1_result}, e);
                end
            end
        end
        if (bus.req0_valid && bus.req0_ready) q0.push_back(exp0);
        if (bus.req1_valid && bus.req1_ready) q1.push_back(exp1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [TAG_W-1:0] tag, input logic [31:0] res);
        bus.req0_valid = 1'b1;
        bus.req0_a = a;
        bus.req0_b = b;
        bus.req0_funct3 = f3;
        bus.req0_funct7 = f7;
        bus.req0_tag = tag;
        exp0 = {tag, res};
    endtask

    task automatic put1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [TAG_W-1:0] tag, input logic [31:0] res);
        bus.req1_valid = 1'b1;
        bus.req1_a = a;
        bus.req1_b = b;
        bus.req1_funct3 = f3;
        bus.req1_funct7 = f7;
        bus.req1_tag = tag;
        exp1 = {tag, res};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        put0(32'd10, 32'd20, 3'b000, 7'd0, 4'd1, 32'd30);
        put1(32'd1, 32'd1, 3'b000, 7'd0, 4'd2, 32'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready cyc=%0d got=%b exp=0", i, bus.req0_ready); end
            total++;
            if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready cyc=%0d got=%b exp=0", i, bus.req1_ready); end
            total++;
            if (bus.rsp0_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp0_valid cyc=%0d got=%b exp=0", i, bus.rsp0_valid); end
            total++;
            if (bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp1_valid cyc=%0d got=%b exp=0", i, bus.rsp1_valid); end
            step;
        end
        total++;
        if ({bus.rsp0_tag, bus.rsp0_result, bus.rsp1_tag, bus.rsp1_result} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0", bus.rsp0_result, bus.rsp1_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        step;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL reset_second_grant got=%b exp=1", bus.req1_ready); end
        step;
        bus.req1_valid = 1'b0;
        step;
        step;
    endtask

    task automatic test_contention;
        int k;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        put0(32'd1, 32'd2, 3'b000, 7'd0, 4'd0, 32'd3);
        put1(32'd3, 32'd4, 3'b011, 7'd0, 4'd1, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL contention_grant cyc=%0d got=%b%b", i, bus.req0_ready, bus.req1_ready);
            end
            if (i == 1) begin
                total++;
                if ({bus.rsp0_valid, bus.rsp0_result} !== {1'b1, 32'd3}) begin
                    bad++;
                    $display("FAIL contention_rsp0 got=%b/%h exp=1/3", bus.rsp0_valid, bus.rsp0_result);
                end
            end
            if (i == 2) begin
                total++;
                if ({bus.rsp1_valid, bus.rsp1_result} !== {1'b1, 32'd1}) begin
                    bad++;
                    $display("FAIL contention_rsp1 got=%b/%h exp=1/1", bus.rsp1_valid, bus.rsp1_result);
                end
            end
            step;
            k = i + 2;
            if (i % 2 == 0) put0(32'(k), 32'd100, 3'b000, 7'd0, k[3:0], 32'(k + 100));
            else put1(32'(k), 32'd100, 3'b000, 7'd0, k[3:0], 32'(k + 100));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step;
        step;
    endtask

    task automatic test_single_op;
        bus.rsp0_ready = 1'b1;
        put0(32'd5, 32'd7, 3'b000, 7'b0100000, 4'd3, 32'hFFFF_FFFE);
        @(negedge clk);
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL single_accept got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        step;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result} !== {1'b1, 4'd3, 32'hFFFF_FFFE}) begin
            bad++;
            $display("FAIL single_rsp got=%b/%h/%h exp=1/3/fffffffe", bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result);
        end
        total++;
        if (bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp1_idle got=%b exp=0", bus.rsp1_valid); end
        step;
        step;
    endtask

    task automatic test_back_pressure;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        put0(32'h12, 32'h30, 3'b110, 7'd0, 4'd6, 32'h32);
        @(negedge clk);
        total++;
        if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL bp_first_accept got=%b exp=1", bus.req0_ready); end
        step;
        put0(32'hFF, 32'h0F, 3'b100, 7'd0, 4'd7, 32'hF0);
        put1(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 7'd0, 4'd8, 32'hF000_F000);
        @(negedge clk);
        total++;
        if ({bus.rsp0_valid, bus.rsp0_result, bus.req0_ready, bus.req1_ready} !== {1'b1, 32'h32, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL bp_blocked got=%b/%h/%b%b exp=1/32/01", bus.rsp0_valid, bus.rsp0_result, bus.req0_ready, bus.req1_ready);
        end
        step;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result, bus.req0_ready} !== {1'b1, 4'd6, 32'h32, 1'b0}) begin
            bad++;
            $display("FAIL bp_stable got=%b/%h/%h/%b exp=1/6/32/0", bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result, bus.req0_ready);
        end
        total++;
        if ({bus.rsp1_valid, bus.rsp1_result} !== {1'b1, 32'hF000_F000}) begin
            bad++;
            $display("FAIL bp_rsp1 got=%b/%h exp=1/f000f000", bus.rsp1_valid, bus.rsp1_result);
        end
        step;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.req0_ready, bus.rsp0_valid} !== 2'b11) begin
            bad++;
            $display("FAIL bp_refill_accept got=%b%b exp=11", bus.req0_ready, bus.rsp0_valid);
        end
        step;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.rsp0_valid, bus.rsp0_result} !== {1'b1, 32'hF0}) begin
            bad++;
            $display("FAIL bp_refill_rsp got=%b/%h exp=1/f0", bus.rsp0_valid, bus.rsp0_result);
        end
        step;
        step;
    endtask

    task automatic test_reset_mid;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        put0(32'd7, 32'd8, 3'b000, 7'd0, 4'd9, 32'd15);
        @(negedge clk);
        total++;
        if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b exp=1", bus.req0_ready); end
        step;
        bus.req0_valid = 1'b0;
        put1(32'd2, 32'd2, 3'b000, 7'd0, 4'd4, 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.rsp0_valid, bus.req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL mid_in_flight got=%b%b exp=10", bus.rsp0_valid, bus.req1_ready);
        end
        step;
        @(negedge clk);
        total++;
        if ({bus.rsp0_valid, bus.rsp0_result} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL mid_discard got=%b/%h exp=0/0", bus.rsp0_valid, bus.rsp0_result);
        end
        q0.delete();
        step;
        rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        put0(32'd9, 32'd1, 3'b000, 7'd0, 4'd5, 32'd10);
        @(negedge clk);
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL mid_prio got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        step;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL mid_req1_after got=%b exp=1", bus.req1_ready); end
        step;
        bus.req1_valid = 1'b0;
        step;
        step;
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL drain_left got=%0d exp=0", q0.size() + q1.size());
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        test_reset;
        test_contention;
        test_single_op;
        test_back_pressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
